// File: rtl/id_ex_pipe_packer_pkg.sv
// Shared widths, ID/EX bundle bit offsets and stage state encodings.
// The execute-side unpacker uses the same offsets.
package id_ex_pipe_packer_pkg;

  localparam int IDEX_DATA_W    = 32;
  localparam int IDEX_CTRL_W    = 54;
  localparam int IDEX_ALUCTRL_W = 38;
  localparam int IDEX_BUNDLE_W  = 4*IDEX_DATA_W + IDEX_CTRL_W + IDEX_ALUCTRL_W;

  localparam int IDEX_INST_HI = 219;
  localparam int IDEX_INST_LO = 188;
  localparam int IDEX_A_HI    = 187;
  localparam int IDEX_A_LO    = 156;
  localparam int IDEX_B_HI    = 155;
  localparam int IDEX_B_LO    = 124;
  localparam int IDEX_CTRL_HI = 123;
  localparam int IDEX_CTRL_LO = 70;
  localparam int IDEX_ALU_HI  = 69;
  localparam int IDEX_ALU_LO  = 32;
  localparam int IDEX_PC_HI   = 31;
  localparam int IDEX_PC_LO   = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_ex_pipe_packer_entry_reg.sv
// One bundle-wide storage entry with load enable; clears on async reset.
module pipe_entry_reg #(
  parameter int W = 220
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/id_ex_pipe_packer.sv
// ID/EX producer stage: packs decode fields into the ID/EX bundle behind a
// main + skid entry pair. Optional counters enabled by PIPE_STAT_EN.
//
// state    | meaning
// ST_EMPTY | no entry held
// ST_ONE   | main entry valid
// ST_FULL  | main and skid valid, upstream stalled
module id_ex_pipe_packer
  import id_ex_pipe_packer_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int CTRL_W    = 54,
  parameter  int ALUCTRL_W = 38,
  localparam int BUNDLE_W  = 4*DATA_W + CTRL_W + ALUCTRL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_inst,
  input  logic [DATA_W-1:0]    in_a_data,
  input  logic [DATA_W-1:0]    in_b_data,
  input  logic [CTRL_W-1:0]    in_control,
  input  logic [ALUCTRL_W-1:0] in_alucontrol,
  input  logic [DATA_W-1:0]    in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUNDLE_W-1:0]  out_bundle
`ifdef PIPE_STAT_EN
  ,
  output logic [31:0]          stat_stall_cnt,
  output logic [31:0]          stat_flush_cnt
`endif
);

  pipe_state_t         state_q, state_nxt;
  logic                in_ready_q;
  logic                accept, issue;
  logic                main_load, main_from_skid, skid_load;
  logic [BUNDLE_W-1:0] in_bundle, main_d, skid_q;

  assign in_bundle = {in_inst, in_a_data, in_b_data, in_control, in_alucontrol, in_pc};

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign issue     = out_valid & out_ready;

  always_comb begin
    state_nxt      = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && issue) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          skid_load = 1'b1;
        end else if (issue) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (issue) begin
          state_nxt      = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins; data regs keep their contents so out_bundle stays stable.
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_bundle;

  pipe_entry_reg #(.W(BUNDLE_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (out_bundle)
  );

  pipe_entry_reg #(.W(BUNDLE_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_bundle),
    .q    (skid_q)
  );

`ifdef PIPE_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        stat_stall_cnt <= sat_inc32(stat_stall_cnt);
      if (flush && (state_q != ST_EMPTY))
        stat_flush_cnt <= sat_inc32(stat_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_packer.sv
// Directed bench for id_ex_pipe_packer; stat checks compile in with PIPE_STAT_EN.
module tb_id_ex_pipe_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_inst, in_a_data, in_b_data, in_pc;
  logic [53:0]  in_control;
  logic [37:0]  in_alucontrol;
  logic         out_valid;
  logic         out_ready;
  logic [219:0] out_bundle;
`ifdef PIPE_STAT_EN
  logic [31:0]  stat_stall_cnt, stat_flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  id_ex_pipe_packer dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_a_data     (in_a_data),
    .in_b_data     (in_b_data),
    .in_control    (in_control),
    .in_alucontrol (in_alucontrol),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bundle    (out_bundle)
`ifdef PIPE_STAT_EN
    ,
    .stat_stall_cnt(stat_stall_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [219:0] obs, input logic [219:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pc(input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = 32'hA000_0000 | pc;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_a_data = '0; in_b_data = '0; in_pc = '0;
    in_control = '0; in_alucontrol = '0;
    #1;
    chk("rst_out_valid", 220'(out_valid), 220'(1'b0));
    chk("rst_in_ready", 220'(in_ready), 220'(1'b1));
    chk("rst_bundle", out_bundle, 220'(0));
    tick(); tick();
    rst = 1'b0;

    // Packing
    in_valid = 1'b1; out_ready = 1'b1;
    in_inst = 32'h8C22_0004; in_a_data = 32'h1111_1111; in_b_data = 32'h2222_2222;
    in_control = 54'h1; in_alucontrol = 38'h2; in_pc = 32'hBFC0_0000;
    tick();
    chk("pack_valid", 220'(out_valid), 220'(1'b1));
    chk("pack_inst", 220'(out_bundle[219:188]), 220'(32'h8C22_0004));
    chk("pack_pc", 220'(out_bundle[31:0]), 220'(32'hBFC0_0000));
    chk("pack_ctrl_bit70", 220'(out_bundle[70]), 220'(1'b1));
    chk("pack_alu_bit33", 220'(out_bundle[33]), 220'(1'b1));
    chk("pack_full", out_bundle,
        {32'h8C22_0004, 32'h1111_1111, 32'h2222_2222, 54'h1, 38'h2, 32'hBFC0_0000});
    in_valid = 1'b0;
    tick();
    chk("pack_drain_valid", 220'(out_valid), 220'(1'b0));
    chk("pack_hold_inst", 220'(out_bundle[219:188]), 220'(32'h8C22_0004));

`ifdef PIPE_STAT_EN
    out_ready = 1'b0;
    push_pc(32'h0000_0050);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("stat_stall", 220'(stat_stall_cnt), 220'(32'd5));
    chk("stat_flush", 220'(stat_flush_cnt), 220'(32'd1));
    chk("stat_after_flush_valid", 220'(out_valid), 220'(1'b0));
`endif

    // Backpressure
    out_ready = 1'b0;
    push_pc(32'h0000_0100);
    tick();
    chk("bp_i0_valid", 220'(out_valid), 220'(1'b1));
    chk("bp_i0_ready", 220'(in_ready), 220'(1'b1));
    push_pc(32'h0000_0104);
    tick();
    chk("bp_full_ready", 220'(in_ready), 220'(1'b0));
    chk("bp_full_pc", 220'(out_bundle[31:0]), 220'(32'h100));
    push_pc(32'h0000_0108);
    tick();
    chk("bp_ignored_ready", 220'(in_ready), 220'(1'b0));
    chk("bp_ignored_pc", 220'(out_bundle[31:0]), 220'(32'h100));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_i1_valid", 220'(out_valid), 220'(1'b1));
    chk("bp_i1_pc", 220'(out_bundle[31:0]), 220'(32'h104));
    chk("bp_ready_back", 220'(in_ready), 220'(1'b1));
    tick();
    chk("bp_empty_valid", 220'(out_valid), 220'(1'b0));

    // Streaming
    for (int i = 0; i < 10; i++) begin
      push_pc(32'h200 + 32'(4*i));
      tick();
      chk($sformatf("stream_valid_%0d", i), 220'(out_valid), 220'(1'b1));
      chk($sformatf("stream_pc_%0d", i), 220'(out_bundle[31:0]), 220'(32'h200 + 32'(4*i)));
      chk($sformatf("stream_ready_%0d", i), 220'(in_ready), 220'(1'b1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 220'(out_valid), 220'(1'b0));

    // Flush from FULL with a simultaneous input
    out_ready = 1'b0;
    push_pc(32'h300); tick();
    push_pc(32'h304); tick();
    chk("fl_full_ready", 220'(in_ready), 220'(1'b0));
    push_pc(32'h308); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 220'(out_valid), 220'(1'b0));
    chk("fl_ready", 220'(in_ready), 220'(1'b1));
    chk("fl_hold_pc", 220'(out_bundle[31:0]), 220'(32'h300));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_no_issue_%0d", i), 220'(out_valid), 220'(1'b0));
    end
    push_pc(32'h400); tick();
    chk("fl_resume_pc", 220'(out_bundle[31:0]), 220'(32'h400));
    in_valid = 1'b0;
    tick();

    // Async reset in FULL, away from the edge
    out_ready = 1'b0;
    push_pc(32'h500); tick();
    push_pc(32'h504); tick();
    in_valid = 1'b0;
    chk("rst2_pre_full", 220'(in_ready), 220'(1'b0));
    #2 rst = 1'b1;
    #1;
    chk("rst2_valid", 220'(out_valid), 220'(1'b0));
    chk("rst2_ready", 220'(in_ready), 220'(1'b1));
    chk("rst2_bundle", out_bundle, 220'(0));
    #2 rst = 1'b0;
    push_pc(32'h600);
    tick();
    chk("rst2_first_accept_valid", 220'(out_valid), 220'(1'b1));
    chk("rst2_first_accept_pc", 220'(out_bundle[31:0]), 220'(32'h600));
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
